// File: rtl/uart_rx.sv
// 8-N-1 UART receiver. It oversamples the asynchronous rx pin with the system clock,
// presents each correctly framed byte with a one-cycle valid strobe, and flags a low stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             sample_tick;

  // The start bit is sampled at its centre; data and stop bits one full period later each.
  always_comb begin
    sample_tick = 1'b0;
    unique case (state_q)
      ST_START:         sample_tick = (cnt_q == HALF_M1);
      ST_DATA, ST_STOP: sample_tick = (cnt_q == FULL_M1);
      default:          sample_tick = 1'b0;
    endcase
  end

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!rx_s_q) state_d = ST_START;
      ST_START: if (sample_tick) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (sample_tick && (idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (sample_tick) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);

    // The bit timer restarts on every state change and at each sample point.
    if ((state_d != state_q) || sample_tick ||
        (state_q == ST_IDLE) || (state_q == ST_BREAK)) begin
      cnt_d = '0;
    end

    unique case (state_q)
      ST_IDLE: idx_d = 3'd0;
      ST_DATA: begin
        if (sample_tick) begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the synchronizer resets to the idle level (1) so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
